// File: rtl/icnbc_sweep_ctrl_if.sv
// Bundle of host configuration, engine control and result stream signals for
// the ICNBC sweep controller. The master side is the controller itself; the
// slave side is whatever surrounds it (host, engine, result consumer).
interface icnbc_sweep_ctrl_if #(
   parameter int N     = 8,
   parameter int CNT_W = 16,
   parameter int TO_W  = 24
);
   // host configuration
   logic             cfg_go;
   logic             cfg_abort;
   logic [N-1:0]     n_lo;
   logic [N-1:0]     n_hi;
   logic [N-1:0]     ld_lo;
   logic [N-1:0]     ld_hi;
   logic [TO_W-1:0]  timeout;
   // engine control
   logic             eng_start;
   logic [N-1:0]     eng_n;
   logic [N-1:0]     eng_min_ld;
   logic             eng_done;
   logic [CNT_W-1:0] eng_count;
   // result stream
   logic             res_valid;
   logic             res_ready;
   logic [N-1:0]     res_n;
   logic [N-1:0]     res_ld;
   logic [CNT_W-1:0] res_count;
   logic             res_timeout;
   // status
   logic             busy;
   logic             sweep_done;
   logic             aborted;
   logic             err_cfg;

   modport master (
      input  cfg_go, cfg_abort, n_lo, n_hi, ld_lo, ld_hi, timeout,
      input  eng_done, eng_count, res_ready,
      output eng_start, eng_n, eng_min_ld,
      output res_valid, res_n, res_ld, res_count, res_timeout,
      output busy, sweep_done, aborted, err_cfg
   );

   modport slave (
      output cfg_go, cfg_abort, n_lo, n_hi, ld_lo, ld_hi, timeout,
      output eng_done, eng_count, res_ready,
      input  eng_start, eng_n, eng_min_ld,
      input  res_valid, res_n, res_ld, res_count, res_timeout,
      input  busy, sweep_done, aborted, err_cfg
   );
endinterface

// File: rtl/icnbc_sweep_ctrl.sv
// ICNBC sweep controller: walks the engine over an inclusive (n, min_ld) grid,
// ld inner loop and n outer loop, starting the engine once per point and
// emitting one result record per point on a valid/ready stream. A point ends
// on engine done or on the optional WAIT timeout; done wins a tie.
module icnbc_sweep_ctrl #(
   parameter int N     = 8,
   parameter int CNT_W = 16,
   parameter int TO_W  = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   icnbc_sweep_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_REPORT,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [N-1:0]     n_hi_q;
   logic [N-1:0]     ld_lo_q;
   logic [N-1:0]     ld_hi_q;
   logic [TO_W-1:0]  timeout_q;
   logic [N-1:0]     cur_n_q;
   logic [N-1:0]     cur_ld_q;
   logic [TO_W-1:0]  tmr_q;
   logic             eng_start_q;
   logic             res_valid_q;
   logic [CNT_W-1:0] res_count_q;
   logic             res_timeout_q;
   logic             sweep_done_q;
   logic             aborted_q;
   logic             err_cfg_q;

   logic [N-1:0]     cur_n_d;
   logic [N-1:0]     cur_ld_d;
   logic             last_ld;
   logic             last_n;
   logic             cfg_bad;
   logic             tmr_expired;

   // Next grid point; bounds are compared before incrementing so a bound of
   // all-ones never has to wrap to reach the end of the sweep.
   always_comb begin
      last_ld  = (cur_ld_q == ld_hi_q);
      last_n   = (cur_n_q == n_hi_q);
      cur_n_d  = cur_n_q;
      cur_ld_d = cur_ld_q + N'(1);
      if (last_ld) begin
         cur_ld_d = ld_lo_q;
         cur_n_d  = cur_n_q + N'(1);
      end
   end

   // Configuration sanity and WAIT timeout decode.
   always_comb begin
      cfg_bad     = (bus.n_lo > bus.n_hi) || (bus.ld_lo > bus.ld_hi) ||
                    (bus.ld_lo == '0);
      tmr_expired = (timeout_q != '0) && (tmr_q == timeout_q - TO_W'(1));
   end

   // Sweep sequencer with registered outputs; pulses default low each cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         n_hi_q        <= '0;
         ld_lo_q       <= '0;
         ld_hi_q       <= '0;
         timeout_q     <= '0;
         cur_n_q       <= '0;
         cur_ld_q      <= '0;
         tmr_q         <= '0;
         eng_start_q   <= 1'b0;
         res_valid_q   <= 1'b0;
         res_count_q   <= '0;
         res_timeout_q <= 1'b0;
         sweep_done_q  <= 1'b0;
         aborted_q     <= 1'b0;
         err_cfg_q     <= 1'b0;
      end else begin
         eng_start_q  <= 1'b0;
         sweep_done_q <= 1'b0;
         aborted_q    <= 1'b0;
         err_cfg_q    <= 1'b0;
         if ((state_q != S_IDLE) && bus.cfg_abort) begin
            // Abandon the sweep; a pending record is dropped.
            state_q     <= S_IDLE;
            aborted_q   <= 1'b1;
            res_valid_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (bus.cfg_go) begin
                     n_hi_q    <= bus.n_hi;
                     ld_lo_q   <= bus.ld_lo;
                     ld_hi_q   <= bus.ld_hi;
                     timeout_q <= bus.timeout;
                     if (cfg_bad) begin
                        err_cfg_q <= 1'b1;
                     end else begin
                        cur_n_q     <= bus.n_lo;
                        cur_ld_q    <= bus.ld_lo;
                        eng_start_q <= 1'b1;
                        state_q     <= S_START;
                     end
                  end
               end
               S_START: begin
                  tmr_q   <= '0;
                  state_q <= S_WAIT;
               end
               S_WAIT: begin
                  tmr_q <= tmr_q + TO_W'(1);
                  if (bus.eng_done) begin
                     res_count_q   <= bus.eng_count;
                     res_timeout_q <= 1'b0;
                     res_valid_q   <= 1'b1;
                     state_q       <= S_REPORT;
                  end else if (tmr_expired) begin
                     res_count_q   <= '0;
                     res_timeout_q <= 1'b1;
                     res_valid_q   <= 1'b1;
                     state_q       <= S_REPORT;
                  end
               end
               S_REPORT: begin
                  if (bus.res_ready) begin
                     res_valid_q <= 1'b0;
                     if (last_ld && last_n) begin
                        sweep_done_q <= 1'b1;
                        state_q      <= S_DONE;
                     end else begin
                        cur_n_q     <= cur_n_d;
                        cur_ld_q    <= cur_ld_d;
                        eng_start_q <= 1'b1;
                        state_q     <= S_START;
                     end
                  end
               end
               S_DONE: begin
                  state_q <= S_IDLE;
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.eng_start   = eng_start_q;
   assign bus.eng_n       = cur_n_q;
   assign bus.eng_min_ld  = cur_ld_q;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_n       = cur_n_q;
   assign bus.res_ld      = cur_ld_q;
   assign bus.res_count   = res_count_q;
   assign bus.res_timeout = res_timeout_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.sweep_done  = sweep_done_q;
   assign bus.aborted     = aborted_q;
   assign bus.err_cfg     = err_cfg_q;

endmodule
